// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Truth-table sweep controller for combinational gate cells.
//               On start it drives every input combination 0..2^N_IN-1 into
//               the gate under test. Each vector is held for SETTLE_CYCLES
//               clocks. The gate output y is sampled on the last settle edge
//               and compared against the expected truth table captured on
//               start.
//
// Parameters  : N_IN           number of gate inputs (1..4)
//               SETTLE_CYCLES  clocks each vector is held before sampling (>=1)
//
// Ports       : clk            clock, rising edge
//               rst            synchronous active-high reset
//               start          sweep request, sampled only while idle
//               exp_tt         expected truth table, bit k is y for gate_in==k
//               y              output of the gate under test
//               gate_in        vector driven to the gate (MSB = input a)
//               busy           high while sweeping
//               done           one-cycle pulse when a sweep completes
//               pass           1 when no vector mismatched (valid from done)
//               result_tt      sampled y per vector
//               fail_count     number of mismatching vectors
//               first_fail_idx lowest mismatching vector index, 0 if none
//
// Build option: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep on the
//               first mismatching sample.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 y,
    output logic [N_IN-1:0]      gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   result_tt,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail_idx
);

    localparam int c_NVEC   = 2**N_IN;
    localparam int c_HOLD_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]     c_IDX_LAST  = N_IN'(c_NVEC - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWEEP = 1'b1;

    logic [0:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_NVEC-1:0]   r_exp_tt;

    logic                w_sample;
    logic                w_mismatch;
    logic                w_last_vec;
    logic                w_end_sweep;
    logic [N_IN:0]       w_fail_next;

    // gate_in doubles as the vector index while sweeping; it is forced to
    // zero whenever the controller is idle.
    assign w_sample    = (r_state == c_ST_SWEEP) && (r_hold == c_HOLD_LAST);
    assign w_mismatch  = (y != r_exp_tt[gate_in]);
    assign w_last_vec  = (gate_in == c_IDX_LAST);
    // Count including the current sample, so the final vector's comparison
    // feeds pass in the same cycle.
    assign w_fail_next = fail_count + {{N_IN{1'b0}}, w_mismatch};

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign w_end_sweep = w_last_vec || w_mismatch;
`else
    assign w_end_sweep = w_last_vec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_hold         <= '0;
            r_exp_tt       <= '0;
            gate_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            result_tt      <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    gate_in <= '0;
                    if (start) begin
                        r_state        <= c_ST_SWEEP;
                        r_exp_tt       <= exp_tt;
                        r_hold         <= '0;
                        result_tt      <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end

                c_ST_SWEEP: begin
                    if (w_sample) begin
                        result_tt[gate_in] <= y;
                        fail_count         <= w_fail_next;
                        if (w_mismatch && (fail_count == '0)) begin
                            first_fail_idx <= gate_in;
                        end
                        if (w_end_sweep) begin
                            r_state <= c_ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_fail_next == '0);
                            gate_in <= '0;
                        end else begin
                            gate_in <= gate_in + N_IN'(1);
                            r_hold  <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    gate_in <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Self-checking bench for gate_sweep_ctrl. Two instances are
//               used: a slow one (N_IN=2, SETTLE_CYCLES=10) and a fast one
//               (N_IN=2, SETTLE_CYCLES=1). The gate under test is modelled
//               as a lookup of a behavioural truth table on gate_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [3:0] exp_tt;
    logic [3:0] gtt;
    logic       selq;

    logic [1:0] gin0, gin1;
    logic       y0, y1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] res0, res1;
    logic [2:0] fc0, fc1;
    logic [1:0] ff0, ff1;

    logic [1:0] m_gin;
    logic       m_busy, m_done, m_pass;
    logic [3:0] m_res;
    logic [2:0] m_fc;
    logic [1:0] m_ff;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural gate under test: output is the truth-table bit for its input.
    assign y0 = gtt[gin0];
    assign y1 = gtt[gin1];

    assign m_gin  = selq ? gin1  : gin0;
    assign m_busy = selq ? busy1 : busy0;
    assign m_done = selq ? done1 : done0;
    assign m_pass = selq ? pass1 : pass0;
    assign m_res  = selq ? res1  : res0;
    assign m_fc   = selq ? fc1   : fc0;
    assign m_ff   = selq ? ff1   : ff0;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(10)) dut_slow (
        .clk(clk), .rst(rst), .start(start0), .exp_tt(exp_tt), .y(y0),
        .gate_in(gin0), .busy(busy0), .done(done0), .pass(pass0),
        .result_tt(res0), .fail_count(fc0), .first_fail_idx(ff0)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut_fast (
        .clk(clk), .rst(rst), .start(start1), .exp_tt(exp_tt), .y(y1),
        .gate_in(gin1), .busy(busy1), .done(done1), .pass(pass1),
        .result_tt(res1), .fail_count(fc1), .first_fail_idx(ff1)
    );

    typedef struct {
        string      name;
        bit         fast;
        logic [3:0] g;
        logic [3:0] e;
        logic [3:0] r;
        int         fc;
        int         ff;
        int         ps;
        int         lat;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: each vector's result bit is simply the gate's truth-table bit;
    // mismatches are the positions where gate and expectation differ.
    task automatic model(input logic [3:0] g, input logic [3:0] e, input int s,
                         output logic [3:0] r, output int fc, output int ff,
                         output int ps, output int lat);
        r = 4'b0; fc = 0; ff = 0; lat = 4 * s;
        for (int k = 0; k < 4; k++) begin
            r[k] = g[k];
            if (g[k] != e[k]) begin
                if (fc == 0) ff = k;
                fc++;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                lat = (k + 1) * s;
                break;
`endif
            end
        end
        ps = (fc == 0) ? 1 : 0;
    endtask

    // Launches a sweep and follows it to done, checking the vector sequence.
    task automatic do_sweep(input bit sel, input logic [3:0] g, input logic [3:0] e,
                            input bit hold_start, output int lat);
        int s;
        int c;
        bit seq_ok;
        bit got;
        selq   = sel;
        gtt    = g;
        exp_tt = e;
        s      = sel ? 1 : 10;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        c = 0; seq_ok = 1'b1; got = 1'b0;
        while (c < 200) begin
            @(negedge clk);
            if (!hold_start) begin start0 = 1'b0; start1 = 1'b0; end
            if (m_done) begin got = 1'b1; break; end
            if ((int'(m_gin) != c / s) || !m_busy) seq_ok = 1'b0;
            if (hold_start && c == 15) exp_tt = 4'b0000;
            c++;
        end
        check("sweep_done_seen", int'(got), 1);
        check("gate_in_sequence", int'(seq_ok), 1);
        lat = c;
    endtask

    task automatic check_outputs(input string nm, input logic [3:0] r, input int fc,
                                 input int ff, input int ps, input int lat_exp,
                                 input int lat);
        check({nm, "_latency"}, lat, lat_exp);
        check({nm, "_result_tt"}, int'(m_res), int'(r));
        check({nm, "_fail_count"}, int'(m_fc), fc);
        check({nm, "_first_fail"}, int'(m_ff), ff);
        check({nm, "_pass"}, int'(m_pass), ps);
        check({nm, "_busy_low"}, int'(m_busy), 0);
        check({nm, "_gate_in_zero"}, int'(m_gin), 0);
    endtask

    task automatic check_pulse_end(input string nm, input logic [3:0] r);
        @(negedge clk);
        check({nm, "_done_one_cycle"}, int'(m_done), 0);
        check({nm, "_result_held"}, int'(m_res), int'(r));
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0] r;
        int fc, ff, ps, lat_e, lat;
        bit seen;

        vecs[0] = '{"and_pass",  1'b0, 4'b1000, 4'b1000, 4'b1000, 0, 0, 1, 40};
        vecs[1] = '{"or_fast",   1'b1, 4'b1110, 4'b1110, 4'b1110, 0, 0, 1, 4};
        vecs[2] = '{"nand_fast", 1'b1, 4'b0111, 4'b0111, 4'b0111, 0, 0, 1, 4};
        vecs[3] = '{"last_only", 1'b0, 4'b0000, 4'b1000, 4'b0000, 1, 3, 0, 40};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        vecs[4] = '{"stuck1",    1'b0, 4'b1111, 4'b1000, 4'b0001, 1, 0, 0, 10};
        vecs[5] = '{"xor_vs_and",1'b0, 4'b0110, 4'b1000, 4'b0010, 1, 1, 0, 20};
        vecs[6] = '{"stuck0",    1'b1, 4'b0000, 4'b1110, 4'b0000, 1, 1, 0, 2};
`else
        vecs[4] = '{"stuck1",    1'b0, 4'b1111, 4'b1000, 4'b1111, 3, 0, 0, 40};
        vecs[5] = '{"xor_vs_and",1'b0, 4'b0110, 4'b1000, 4'b0110, 3, 1, 0, 40};
        vecs[6] = '{"stuck0",    1'b1, 4'b0000, 4'b1110, 4'b0000, 3, 1, 0, 4};
`endif

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        exp_tt = 4'b0; gtt = 4'b0; selq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy0 | busy1), 0);
        check("reset_done", int'(done0 | done1), 0);
        check("reset_pass", int'(pass0 | pass1), 0);
        check("reset_gate_in", int'(gin0 | gin1), 0);
        check("reset_result", int'(res0 | res1), 0);
        check("reset_fail_count", int'(fc0 | fc1), 0);
        check("reset_first_fail", int'(ff0 | ff1), 0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            do_sweep(vecs[i].fast, vecs[i].g, vecs[i].e, 1'b0, lat);
            check_outputs(vecs[i].name, vecs[i].r, vecs[i].fc, vecs[i].ff,
                          vecs[i].ps, vecs[i].lat, lat);
            check_pulse_end(vecs[i].name, vecs[i].r);
        end

        // Reset in the middle of a sweep: y stuck at 1 leaves a nonzero result.
        selq = 1'b0; gtt = 4'b1111; exp_tt = 4'b1111;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_result", int'(res0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy0), 0);
        check("midrst_gate_in", int'(gin0), 0);
        check("midrst_done", int'(done0), 0);
        check("midrst_result", int'(res0), 0);
        check("midrst_fail_count", int'(fc0), 0);
        check("midrst_first_fail", int'(ff0), 0);
        check("midrst_pass", int'(pass0), 0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done0 || busy0) seen = 1'b1;
        end
        check("midrst_no_done", int'(seen), 0);
        do_sweep(1'b0, 4'b1000, 4'b1000, 1'b0, lat);
        check_outputs("restart", 4'b1000, 0, 0, 1, 40, lat);

        // start held high and exp_tt changed mid-sweep.
        do_sweep(1'b0, 4'b1000, 4'b1000, 1'b1, lat);
        check_outputs("held_start", 4'b1000, 0, 0, 1, 40, lat);
        @(negedge clk);
        check("restart_on_done_busy", int'(busy0), 1);
        check("restart_on_done_pulse", int'(done0), 0);
        check("restart_on_done_gate_in", int'(gin0), 0);
        start0 = 1'b0;
        exp_tt = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done0) begin seen = 1'b1; break; end
        end
        check("second_sweep_done", int'(seen), 1);
        // The second sweep captured the 0000 present on the done edge.
        check("second_sweep_fail_count", int'(fc0), 1);
        check("second_sweep_first_fail", int'(ff0), 3);
        check("second_sweep_pass", int'(pass0), 0);

        // Randomized sweeps against the reference model.
        for (int i = 0; i < 24; i++) begin
            bit sel;
            logic [3:0] g, e;
            sel = 1'($urandom_range(0, 1));
            g   = 4'($urandom);
            e   = ($urandom_range(0, 1) == 1) ? g : 4'($urandom);
            model(g, e, sel ? 1 : 10, r, fc, ff, ps, lat_e);
            do_sweep(sel, g, e, 1'b0, lat);
            check_outputs("random", r, fc, ff, ps, lat_e, lat);
            check_pulse_end("random", r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
